// File: rtl/carry_lookahead_adder.sv
// Registered unsigned adder built from 4-way carry-lookahead levels.
// s holds the full DWL+1 bit sum one cycle after the operands are sampled.
module carry_lookahead_adder #(
    parameter int DWL = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DWL-1:0] a,
    input  logic [DWL-1:0] b,
    output logic [DWL:0]   s,
    output logic           cout
);

    function automatic int calc_levels(input int n);
        int l;
        int w;
        l = 1;
        w = 4;
        while (w < n) begin
            w = w * 4;
            l = l + 1;
        end
        return l;
    endfunction

    localparam int NL = calc_levels(DWL);
    localparam int W  = 1 << (2 * NL);

    // Carries into each of four children, expanded to sum-of-products.
    function automatic logic [3:0] cla4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       ci
    );
        logic [3:0] c;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);
        return c;
    endfunction

    function automatic logic grp_g(
        input logic [3:0] g,
        input logic [3:0] p
    );
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    logic [W-1:0] gv [NL+1];
    logic [W-1:0] pv [NL+1];
    logic [W-1:0] cv [NL+1];
    logic [W:0]   cext;
    logic [DWL:0] sum;

    always_comb begin
        for (int l = 0; l <= NL; l++) begin
            gv[l] = '0;
            pv[l] = '0;
            cv[l] = '0;
        end
        // Bits above DWL stay g=p=0, so padding cannot disturb carries.
        gv[0][DWL-1:0] = a & b;
        pv[0][DWL-1:0] = a ^ b;
        for (int l = 1; l <= NL; l++) begin
            for (int j = 0; j < (W >> (2 * l)); j++) begin
                gv[l][j] = grp_g(gv[l-1][4*j +: 4], pv[l-1][4*j +: 4]);
                pv[l][j] = &pv[l-1][4*j +: 4];
            end
        end
        cv[NL][0] = 1'b0;
        for (int l = NL; l >= 1; l--) begin
            for (int j = 0; j < (W >> (2 * l)); j++) begin
                cv[l-1][4*j +: 4] = cla4(gv[l-1][4*j +: 4],
                                         pv[l-1][4*j +: 4],
                                         cv[l][j]);
            end
        end
        cext = {gv[NL][0], cv[0]};
        sum  = {cext[DWL], pv[0][DWL-1:0] ^ cv[0][DWL-1:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s    <= '0;
            cout <= 1'b0;
        end else begin
            s    <= sum;
            cout <= sum[DWL];
        end
    end

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and short random checks of carry_lookahead_adder
// at widths 1, 4, 7, 16 and 32.
module tb_carry_lookahead_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:0]  a1 = '0, b1 = '0;
    logic [3:0]  a4 = 4'hF, b4 = 4'hF;
    logic [6:0]  a7 = '0, b7 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [1:0]  s1;
    logic [4:0]  s4;
    logic [7:0]  s7;
    logic [16:0] s16;
    logic [32:0] s32;
    logic        c1, c4, c7, c16, c32;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.DWL(1)) u1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .s(s1), .cout(c1));
    carry_lookahead_adder #(.DWL(4)) u4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .s(s4), .cout(c4));
    carry_lookahead_adder #(.DWL(7)) u7 (
        .clk(clk), .rst(rst), .a(a7), .b(b7), .s(s7), .cout(c7));
    carry_lookahead_adder #(.DWL(16)) u16 (
        .clk(clk), .rst(rst), .a(a16), .b(b16), .s(s16), .cout(c16));
    carry_lookahead_adder #(.DWL(32)) u32 (
        .clk(clk), .rst(rst), .a(a32), .b(b32), .s(s32), .cout(c32));

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic v4(input logic [3:0] x, input logic [3:0] y,
                      input logic [4:0] es, input logic ec, input string tag);
        a4 = x;
        b4 = y;
        tick();
        chk({tag, "_s"}, 64'(s4), 64'(es));
        chk({tag, "_c"}, 64'(c4), 64'(ec));
    endtask

    initial begin
        logic [4:0]  e4;
        logic [16:0] e16;
        logic [32:0] e32;
        logic        r;

        #1;
        chk("rst_s", 64'(s4), 64'd0);
        chk("rst_c", 64'(c4), 64'd0);
        repeat (2) tick();
        chk("rst_hold_s", 64'(s4), 64'd0);
        chk("rst_hold_c", 64'(c4), 64'd0);
        rst = 1'b0;
        tick();
        chk("first_s", 64'(s4), 64'd30);
        chk("first_c", 64'(c4), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_s", 64'(s4), 64'd0);
        chk("async_c", 64'(c4), 64'd0);
        tick();
        rst = 1'b0;

        v4(4'h0, 4'h0, 5'd0,  1'b0, "zero");
        v4(4'hF, 4'hF, 5'd30, 1'b1, "max");
        v4(4'hE, 4'h7, 5'd21, 1'b1, "mix");
        v4(4'hA, 4'h5, 5'd15, 1'b0, "allprop");
        v4(4'h8, 4'h8, 5'd16, 1'b1, "topbit");
        v4(4'h3, 4'h4, 5'd7,  1'b0, "b2b0");
        v4(4'h9, 4'h9, 5'd18, 1'b1, "b2b1");

        a4 = 4'h1;
        b4 = 4'h1;
        #2;
        chk("hold_between_edges", 64'(s4), 64'd18);
        tick();
        chk("latency", 64'(s4), 64'd2);

        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            tick();
            chk("w1_s", 64'(s1), 64'(i[1] + i[0]));
            chk("w1_c", 64'(c1), 64'(i[1] & i[0]));
        end

        a7 = 7'd127; b7 = 7'd1;
        a16 = 16'hFFFF; b16 = 16'h0001;
        a32 = 32'hFFFF_FFFF; b32 = 32'h1;
        tick();
        chk("w7_s", 64'(s7), 64'd128);
        chk("w7_c", 64'(c7), 64'd1);
        chk("w16_s", 64'(s16), 64'h10000);
        chk("w16_c", 64'(c16), 64'd1);
        chk("w32_s", 64'(s32), 64'h1_0000_0000);
        chk("w32_c", 64'(c32), 64'd1);
        a7 = 7'd64; b7 = 7'd63;
        a16 = 16'hFFFF; b16 = 16'hFFFF;
        tick();
        chk("w7b_s", 64'(s7), 64'd127);
        chk("w7b_c", 64'(c7), 64'd0);
        chk("w16b_s", 64'(s16), 64'h1FFFE);

        for (int i = 0; i < 300; i++) begin
            a4  = 4'($urandom);
            b4  = 4'($urandom);
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            a32 = $urandom;
            b32 = $urandom;
            r   = ($urandom_range(0, 19) == 0);
            e4  = {1'b0, a4} + {1'b0, b4};
            e16 = {1'b0, a16} + {1'b0, b16};
            e32 = {1'b0, a32} + {1'b0, b32};
            rst = r;
            tick();
            rst = 1'b0;
            if (r) begin
                e4  = '0;
                e16 = '0;
                e32 = '0;
            end
            chk("rnd4_s", 64'(s4), 64'(e4));
            chk("rnd4_c", 64'(c4), 64'(s4[4]));
            chk("rnd16_s", 64'(s16), 64'(e16));
            chk("rnd16_c", 64'(c16), 64'(e16[16]));
            chk("rnd32_s", 64'(s32), 64'(e32));
            chk("rnd32_c", 64'(c32), 64'(e32[32]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/carry_lookahead_adder.md
# carry_lookahead_adder

Registered, parameterizable unsigned adder built on carry-lookahead logic: adds two DWL-bit operands with zero carry-in and presents the full (DWL+1)-bit sum plus a separate carry-out flag. It serves as the fast-carry arithmetic leaf in datapaths, where ripple-carry delay is unacceptable. Its outputs are registered, so it drops into a pipeline stage with one cycle of latency.

## Interface
- DWL, default 4: operand width in bits; any integer ≥ 1.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; clears all output registers.
- a  input  DWL  unsigned operand A.
- b  input  DWL  unsigned operand B.
- s  output  DWL+1  registered sum a+b; s[DWL] is the carry out of the MSB.
- cout  output  1  registered carry-out; always equal to s[DWL].

## Operation
- Per bit i: generate g[i] = a[i] & b[i]; propagate p[i] = a[i] ^ b[i].
- Carry-in to bit 0 is fixed at 0; there is no cin port.
- Carries are computed hierarchically, never by ripple:
  - bits are grouped into 4-bit lookahead blocks;
  - each block produces its internal carries c[k+1] = g[k] | p[k]&c[k], expanded to sum-of-products form, plus group signals G and P;
  - a second-level lookahead unit combines the group G/P values into the block carry-ins;
  - for DWL > 16, a further level is added in the same 4-way pattern.
- Partial groups: when DWL is not a multiple of 4, the top group is padded with p=0, g=0, which cannot alter the result.
- Sum bits: sum[i] = p[i] ^ c[i]; sum[DWL] = c[DWL] (final carry).
- Arithmetic:
  - combinational result = {1'b0,a} + {1'b0,b}, exact and unsigned;
  - there is no overflow or wrap-around, because the DWL+1 result width holds the maximum 2·(2^DWL−1).
- Registering:
  - s <= combinational sum; cout <= c[DWL];
  - both registers are updated on every rising clk edge while rst is low;
  - there is no enable or handshake.
- Functional equivalence: the output must equal a behavioural a+b for all inputs and all DWL.

## Timing
- Latency: 1 cycle. Inputs present before rising edge N appear on s/cout after edge N.
- Throughput: one addition per cycle; back-to-back operand changes are all captured.
- Reset:
  - rst high forces s = 0 and cout = 0 immediately, independent of clk;
  - both stay 0 for as long as rst is high.
- Reset mid-operation:
  - an in-flight result is discarded;
  - the first valid result after deassertion is the operand pair sampled at the first rising edge with rst low.
- Input changes between edges have no effect on the outputs; the outputs are glitch-free registers.
- Critical path: one lookahead level per 4× width, i.e. logarithmic in DWL, with no ripple chain across groups.

## Test plan
- Reset: assert rst with a=4'hF, b=4'hF and clock running -> s=5'b00000 and cout=0 throughout, both cleared without waiting for a clock edge.
- Zero and maximum, DWL=4: a=0000, b=0000 -> after one edge, s=00000, cout=0. Then a=1111, b=1111 -> s=11110 (30), cout=1.
- Mixed carries, DWL=4:
  - a=1110, b=0111 -> s=10101 (21), cout=1;
  - a=1010, b=0101 -> s=01111 (15), cout=0, the all-propagate case with no generate.
- Single top-bit carry, DWL=4: a=1000, b=1000 -> s=10000 (16), cout=1. Also check back-to-back vectors on consecutive cycles, each appearing exactly one cycle later.
- Width scaling:
  - DWL=1: exhaustive, e.g. 1+1 -> s=2'b10, cout=1;
  - DWL=7 (partial group): 127+1 -> s=128, cout=1;
  - DWL=16: 0xFFFF+0x0001 -> s=0x10000, cout=1, with a long propagate across all groups.
- Random: 10k random a/b per DWL in {4,7,16,32}, compared against a behavioural a+b delayed one cycle; cout==s[DWL] checked every cycle, and reset is pulsed randomly mid-stream.
